parking_controller: RTL and testbench
=====================================

PARKING_CONTROLLER -- requirements
Module: parking_controller

Interface
REQ-001 The block SHALL have parameter NUM_SLOTS, default 4, number of parking slots (2..64).
REQ-002 The block SHALL have parameter TICK_DIV, default 40000000, clk cycles per blink half-period.
REQ-003 The block SHALL have parameter FULL_TOGGLES, default 6, full_light toggles per rejected entry.
REQ-004 The block SHALL have parameter DOOR_TOGGLES, default 20, door_light toggles per door cycle.
REQ-005 The block SHALL have localparam SLOT_W = max(1, clog2(NUM_SLOTS)).
REQ-006 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-007 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 The block SHALL have port entry_n  input  1  entry sensor, active-low, synchronous to clk.
REQ-009 The block SHALL have port exit_n  input  1  exit sensor, active-low, synchronous to clk.
REQ-010 The block SHALL have port exit_slot  input  SLOT_W  slot being vacated, sampled on the exit event.
REQ-011 The block SHALL have port full_light  output  1  blinking "lot full" indicator.
REQ-012 The block SHALL have port door_light  output  1  blinking "door open" indicator.
REQ-013 The block SHALL have port occupied  output  NUM_SLOTS  per-slot occupancy bitmap.
REQ-014 The block SHALL have port free_count  output  SLOT_W+1  number of free slots.
REQ-015 The block SHALL have port next_free  output  SLOT_W  lowest-index free slot (0 when none).
REQ-016 The block SHALL have port next_free_valid  output  1  high when at least one slot is free.
REQ-017 The block SHALL have port assign_pulse  output  1  one-cycle pulse when a slot is granted on entry.
REQ-018 The block SHALL have port reject_pulse  output  1  one-cycle pulse on a rejected entry or an invalid exit.

Function
REQ-019 Events SHALL be falling edges: entry_evt = entry_q & ~entry_n, where entry_q is entry_n registered; exit_evt is defined the same way.
REQ-020 The FSM states SHALL be IDLE, ENTRY, EXIT, DOOR and FULL.
REQ-021 Events SHALL be acted on only in IDLE; events in other states SHALL be dropped.
REQ-022 In IDLE, entry_evt SHALL go to ENTRY, else exit_evt SHALL go to EXIT with exit_slot captured; simultaneous events SHALL resolve to entry, and the exit event SHALL be dropped.
REQ-023 In ENTRY with next_free_valid=1, the block SHALL set occupied[next_free], pulse assign_pulse and go to DOOR; with next_free_valid=0 it SHALL pulse reject_pulse and go to FULL.
REQ-024 In EXIT, if the captured slot is < NUM_SLOTS and occupied, it SHALL be cleared and the FSM SHALL go to DOOR; otherwise the block SHALL pulse reject_pulse and return to IDLE.
REQ-025 The blink timer SHALL restart at state entry and toggle the active light every TICK_DIV cycles.
REQ-026 DOOR SHALL exit to IDLE after DOOR_TOGGLES toggles, and FULL after FULL_TOGGLES toggles; the light SHALL be 0 on exit.
REQ-027 The inactive light SHALL be held at 0.
REQ-028 free_count SHALL equal NUM_SLOTS minus popcount(occupied) and be updated the same cycle as occupied.
REQ-029 next_free and next_free_valid SHALL be combinational from occupied, with lowest index first.
REQ-030 free_count SHALL never underflow or exceed NUM_SLOTS.

Reset
REQ-031 On reset, the FSM SHALL be IDLE, occupied=0, free_count=NUM_SLOTS, lights=0, pulses=0, timer=0, and entry_q/exit_q=1.
REQ-032 Reset mid-DOOR/FULL SHALL abort the cycle and force the lights low on the next edge.

Structure
REQ-033 Package parking_pkg SHALL hold the state enum and the default timing constants.
REQ-034 Sub-module blink_timer (start, tick divider, toggle count, done, light) SHALL be instantiated once and shared by DOOR and FULL.

Verification (NUM_SLOTS=4, TICK_DIV=4, FULL_TOGGLES=6, DOOR_TOGGLES=4)
REQ-035 Four entries spaced 30 cycles apart SHALL assign slots 0, 1, 2, 3 in order, with free_count going 4->0 and each door_light showing 4 toggles at a 4-cycle spacing.
REQ-036 A fifth entry when full SHALL raise reject_pulse, and full_light SHALL toggle 6 times, return to 0 and leave occupied=4'b1111.
REQ-037 An exit with exit_slot=1 from full SHALL give occupied=4'b1101 and free_count=1, and the next entry SHALL reassign slot 1.
REQ-038 An exit on an empty slot (exit_slot=2, occupied=0) SHALL raise reject_pulse with no door cycle.
REQ-039 Simultaneous entry_n/exit_n falls in IDLE with occupied=4'b0001 SHALL assign slot 1, drop the exit and leave occupied=4'b0011.
REQ-040 Reset asserted on the 3rd cycle of DOOR SHALL drive door_light=0, occupied=0 and IDLE on the next edge.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and default timing for the parking lot controller.
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_EXIT  = 3'd2,
    ST_DOOR  = 3'd3,
    ST_FULL  = 3'd4
  } state_e;

  localparam int DEF_NUM_SLOTS    = 4;
  localparam int DEF_TICK_DIV     = 40000000;
  localparam int DEF_FULL_TOGGLES = 6;
  localparam int DEF_DOOR_TOGGLES = 20;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/parking_blink_timer.sv
// Blink generator shared by the door and full indicators: restarts on start,
// toggles every TICK_DIV cycles and finishes low after the requested toggles.
module blink_timer
  import parking_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int MAX_TOGGLES = DEF_DOOR_TOGGLES,
  localparam int CNT_W = max_int(1, $clog2(TICK_DIV)),
  localparam int TOG_W = max_int(1, $clog2(MAX_TOGGLES + 1))
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [TOG_W-1:0] toggles,
  output logic             done,
  output logic             light
);

  logic             active_r;
  logic [CNT_W-1:0] cnt_r;
  logic [TOG_W-1:0] tog_r;
  logic [TOG_W-1:0] target_r;
  logic             light_r;
  logic             tick_s;
  logic             last_s;

  // Tick and final-toggle detection
  always_comb begin
    tick_s = active_r & (cnt_r == CNT_W'(TICK_DIV - 1));
    last_s = tick_s & (tog_r == (target_r - TOG_W'(1)));
  end

  // Divider, toggle counter and light register
  always_ff @(posedge clk) begin
    if (reset) begin
      active_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      tog_r    <= {TOG_W{1'b0}};
      target_r <= {TOG_W{1'b0}};
      light_r  <= 1'b0;
    end else if (start) begin
      active_r <= 1'b1;
      cnt_r    <= {CNT_W{1'b0}};
      tog_r    <= {TOG_W{1'b0}};
      target_r <= toggles;
      light_r  <= 1'b0;
    end else if (last_s) begin
      // the final toggle always lands the light at 0, even for odd counts
      active_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      tog_r    <= {TOG_W{1'b0}};
      light_r  <= 1'b0;
    end else if (tick_s) begin
      cnt_r   <= {CNT_W{1'b0}};
      tog_r   <= tog_r + TOG_W'(1);
      light_r <= ~light_r;
    end else if (active_r) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= {CNT_W{1'b0}};
    end
  end

  assign done  = last_s;
  assign light = light_r;

endmodule

// File: rtl/parking_controller.sv
// Parking lot controller: slot allocation on entry, release on exit, and
// blinking door/full indicators driven by one shared blink timer.
module parking_controller
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS    = DEF_NUM_SLOTS,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int FULL_TOGGLES = DEF_FULL_TOGGLES,
  parameter int DOOR_TOGGLES = DEF_DOOR_TOGGLES,
  localparam int SLOT_W = max_int(1, $clog2(NUM_SLOTS))
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entry_n,
  input  logic                 exit_n,
  input  logic [SLOT_W-1:0]    exit_slot,
  output logic                 full_light,
  output logic                 door_light,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic [SLOT_W:0]      free_count,
  output logic [SLOT_W-1:0]    next_free,
  output logic                 next_free_valid,
  output logic                 assign_pulse,
  output logic                 reject_pulse
);

  localparam int MAX_TOG = max_int(FULL_TOGGLES, DOOR_TOGGLES);
  localparam int TOG_W   = max_int(1, $clog2(MAX_TOG + 1));

  state_e               state_r;
  state_e               state_next_s;
  logic                 entry_q_r;
  logic                 exit_q_r;
  logic                 entry_evt_s;
  logic                 exit_evt_s;
  logic [SLOT_W-1:0]    exit_slot_r;
  logic [NUM_SLOTS-1:0] occupied_r;
  logic [NUM_SLOTS-1:0] occupied_next_s;
  logic [SLOT_W:0]      free_count_r;
  logic [SLOT_W-1:0]    next_free_s;
  logic                 next_free_valid_s;
  logic                 exit_hit_s;
  logic                 assign_pulse_r;
  logic                 reject_pulse_r;
  logic                 set_occ_s;
  logic                 clr_occ_s;
  logic                 assign_s;
  logic                 reject_s;
  logic                 capture_exit_s;
  logic                 timer_start_s;
  logic [TOG_W-1:0]     timer_toggles_s;
  logic                 timer_done_s;
  logic                 timer_light_s;

  function automatic logic [SLOT_W:0] popcount(input logic [NUM_SLOTS-1:0] v);
    logic [SLOT_W:0] c;
    c = {(SLOT_W+1){1'b0}};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      c = c + {{SLOT_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Falling-edge event detection on the active-low sensors
  always_comb begin
    entry_evt_s = entry_q_r & ~entry_n;
    exit_evt_s  = exit_q_r & ~exit_n;
  end

  // Lowest free slot, and whether the captured exit slot is a real occupied one
  always_comb begin
    next_free_s       = {SLOT_W{1'b0}};
    next_free_valid_s = ~(&occupied_r);
    exit_hit_s        = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      next_free_s = (!occupied_r[i]) ? SLOT_W'(i) : next_free_s;
      exit_hit_s  = exit_hit_s | ((exit_slot_r == SLOT_W'(i)) & occupied_r[i]);
    end
  end

  // Next occupancy bitmap from the grant/release strobes
  always_comb begin
    occupied_next_s = occupied_r;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      occupied_next_s[i] = (occupied_r[i] | (set_occ_s & (next_free_s == SLOT_W'(i))))
                           & ~(clr_occ_s & (exit_slot_r == SLOT_W'(i)));
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state and control strobes; events outside IDLE are ignored
  always_comb begin
    state_next_s    = state_r;
    set_occ_s       = 1'b0;
    clr_occ_s       = 1'b0;
    assign_s        = 1'b0;
    reject_s        = 1'b0;
    capture_exit_s  = 1'b0;
    timer_start_s   = 1'b0;
    timer_toggles_s = TOG_W'(DOOR_TOGGLES);
    case (state_r)
      ST_IDLE: begin
        if (entry_evt_s) begin
          state_next_s = ST_ENTRY;
        end else if (exit_evt_s) begin
          state_next_s   = ST_EXIT;
          capture_exit_s = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ENTRY: begin
        timer_start_s = 1'b1;
        if (next_free_valid_s) begin
          set_occ_s    = 1'b1;
          assign_s     = 1'b1;
          state_next_s = ST_DOOR;
        end else begin
          reject_s        = 1'b1;
          timer_toggles_s = TOG_W'(FULL_TOGGLES);
          state_next_s    = ST_FULL;
        end
      end
      ST_EXIT: begin
        if (exit_hit_s) begin
          clr_occ_s     = 1'b1;
          timer_start_s = 1'b1;
          state_next_s  = ST_DOOR;
        end else begin
          reject_s     = 1'b1;
          state_next_s = ST_IDLE;
        end
      end
      ST_DOOR: begin
        if (timer_done_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DOOR;
        end
      end
      ST_FULL: begin
        if (timer_done_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Sensor history, occupancy, free count and result pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q_r      <= 1'b1;
      exit_q_r       <= 1'b1;
      exit_slot_r    <= {SLOT_W{1'b0}};
      occupied_r     <= {NUM_SLOTS{1'b0}};
      free_count_r   <= (SLOT_W+1)'(NUM_SLOTS);
      assign_pulse_r <= 1'b0;
      reject_pulse_r <= 1'b0;
    end else begin
      entry_q_r      <= entry_n;
      exit_q_r       <= exit_n;
      exit_slot_r    <= capture_exit_s ? exit_slot : exit_slot_r;
      occupied_r     <= occupied_next_s;
      free_count_r   <= (SLOT_W+1)'(NUM_SLOTS) - popcount(occupied_next_s);
      assign_pulse_r <= assign_s;
      reject_pulse_r <= reject_s;
    end
  end

  blink_timer #(
    .TICK_DIV    (TICK_DIV),
    .MAX_TOGGLES (MAX_TOG)
  ) u_blink_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (timer_start_s),
    .toggles (timer_toggles_s),
    .done    (timer_done_s),
    .light   (timer_light_s)
  );

  // The shared timer's light is steered to whichever indicator owns the state
  assign door_light      = timer_light_s & (state_r == ST_DOOR);
  assign full_light      = timer_light_s & (state_r == ST_FULL);
  assign occupied        = occupied_r;
  assign free_count      = free_count_r;
  assign next_free       = next_free_s;
  assign next_free_valid = next_free_valid_s;
  assign assign_pulse    = assign_pulse_r;
  assign reject_pulse    = reject_pulse_r;

endmodule

// File: tb/tb_parking_controller.sv
// Directed bench for parking_controller with NUM_SLOTS=4, TICK_DIV=4,
// FULL_TOGGLES=6, DOOR_TOGGLES=4.
module tb_parking_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_n;
  logic       exit_n;
  logic [1:0] exit_slot;
  logic       full_light;
  logic       door_light;
  logic [3:0] occupied;
  logic [2:0] free_count;
  logic [1:0] next_free;
  logic       next_free_valid;
  logic       assign_pulse;
  logic       reject_pulse;

  int n_total = 0;
  int n_bad   = 0;

  parking_controller #(
    .NUM_SLOTS    (4),
    .TICK_DIV     (4),
    .FULL_TOGGLES (6),
    .DOOR_TOGGLES (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .entry_n         (entry_n),
    .exit_n          (exit_n),
    .exit_slot       (exit_slot),
    .full_light      (full_light),
    .door_light      (door_light),
    .occupied        (occupied),
    .free_count      (free_count),
    .next_free       (next_free),
    .next_free_valid (next_free_valid),
    .assign_pulse    (assign_pulse),
    .reject_pulse    (reject_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drop the requested sensors for one cycle; returns on the negedge after the event edge
  task automatic drive_events(input bit do_entry, input bit do_exit, input logic [1:0] slot);
    @(negedge clk);
    exit_slot = slot;
    if (do_entry) entry_n = 1'b0;
    if (do_exit)  exit_n  = 1'b0;
    @(negedge clk);
    entry_n = 1'b1;
    exit_n  = 1'b1;
  endtask

  task automatic wait_pulse(output bit got_a, output bit got_r);
    got_a = 1'b0;
    got_r = 1'b0;
    for (int i = 0; i < 8 && !(got_a || got_r); i++) begin
      @(negedge clk);
      got_a = assign_pulse;
      got_r = reject_pulse;
    end
  endtask

  task automatic observe(input int window, input bit watch_full, output int toggles,
                         output bit spacing_ok, output logic final_v, output int other_high);
    logic prev;
    logic cur;
    int   last;
    prev       = watch_full ? full_light : door_light;
    cur        = prev;
    last       = 0;
    toggles    = 0;
    spacing_ok = 1'b1;
    other_high = 0;
    for (int c = 1; c <= window; c++) begin
      @(negedge clk);
      cur = watch_full ? full_light : door_light;
      if (cur !== prev) begin
        toggles++;
        if (c - last != 4) spacing_ok = 1'b0;
        last = c;
        prev = cur;
      end
      if ((watch_full ? door_light : full_light) !== 1'b0) other_high++;
    end
    final_v = cur;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         a;
    bit         r;
    int         tog;
    bit         sp;
    logic       fv;
    int         oh;
    logic [3:0] occ_tab [4];
    logic [1:0] nf_tab  [4];
    occ_tab = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    nf_tab  = '{2'd1, 2'd2, 2'd3, 2'd0};

    reset = 1'b1; entry_n = 1'b1; exit_n = 1'b1; exit_slot = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_occupied", occupied, 4'b0000);
    chk("rst_free", free_count, 3'd4);
    chk("rst_door", door_light, 1'b0);
    chk("rst_full", full_light, 1'b0);
    chk("rst_assign", assign_pulse, 1'b0);
    chk("rst_reject", reject_pulse, 1'b0);
    chk("rst_next_free", next_free, 2'd0);
    chk("rst_nf_valid", next_free_valid, 1'b1);

    // four entries fill slots 0..3 in order
    for (int k = 0; k < 4; k++) begin
      drive_events(1'b1, 1'b0, 2'd0);
      wait_pulse(a, r);
      chk("fill_assign", a, 1'b1);
      chk("fill_reject", r, 1'b0);
      chk("fill_occupied", occupied, occ_tab[k]);
      chk("fill_free", free_count, 3'(3 - k));
      observe(28, 1'b0, tog, sp, fv, oh);
      chk("fill_door_toggles", tog, 4);
      chk("fill_door_spacing", sp, 1'b1);
      chk("fill_door_final", fv, 1'b0);
      chk("fill_full_quiet", oh, 0);
      chk("fill_next_free", next_free, nf_tab[k]);
      chk("fill_nf_valid", next_free_valid, (k < 3) ? 1'b1 : 1'b0);
    end

    // entry when full is rejected and blinks full_light
    drive_events(1'b1, 1'b0, 2'd0);
    wait_pulse(a, r);
    chk("full_assign", a, 1'b0);
    chk("full_reject", r, 1'b1);
    observe(32, 1'b1, tog, sp, fv, oh);
    chk("full_toggles", tog, 6);
    chk("full_spacing", sp, 1'b1);
    chk("full_final", fv, 1'b0);
    chk("full_door_quiet", oh, 0);
    chk("full_occupied", occupied, 4'b1111);
    chk("full_free", free_count, 3'd0);

    // exit slot 1 then re-enter gets slot 1 back
    drive_events(1'b0, 1'b1, 2'd1);
    @(negedge clk);
    chk("exit1_occupied", occupied, 4'b1101);
    chk("exit1_free", free_count, 3'd1);
    chk("exit1_reject", reject_pulse, 1'b0);
    observe(28, 1'b0, tog, sp, fv, oh);
    chk("exit1_door_toggles", tog, 4);
    chk("exit1_next_free", next_free, 2'd1);
    drive_events(1'b1, 1'b0, 2'd0);
    wait_pulse(a, r);
    chk("reenter_assign", a, 1'b1);
    chk("reenter_occupied", occupied, 4'b1111);
    @(negedge clk);
    chk("pulse_width", assign_pulse, 1'b0);
    repeat (28) @(negedge clk);

    // exit of an empty slot is rejected without a door cycle
    do_reset();
    drive_events(1'b0, 1'b1, 2'd2);
    wait_pulse(a, r);
    chk("bad_exit_reject", r, 1'b1);
    chk("bad_exit_assign", a, 1'b0);
    observe(20, 1'b0, tog, sp, fv, oh);
    chk("bad_exit_no_door", tog, 0);
    chk("bad_exit_occupied", occupied, 4'b0000);
    chk("bad_exit_free", free_count, 3'd4);

    // simultaneous entry/exit: entry wins, exit dropped
    drive_events(1'b1, 1'b0, 2'd0);
    wait_pulse(a, r);
    repeat (28) @(negedge clk);
    chk("simul_pre_occ", occupied, 4'b0001);
    drive_events(1'b1, 1'b1, 2'd0);
    wait_pulse(a, r);
    chk("simul_assign", a, 1'b1);
    chk("simul_occupied", occupied, 4'b0011);
    observe(28, 1'b0, tog, sp, fv, oh);
    chk("simul_door_toggles", tog, 4);
    chk("simul_exit_dropped", occupied, 4'b0011);
    chk("simul_free", free_count, 3'd2);

    // reset on the third DOOR cycle
    drive_events(1'b1, 1'b0, 2'd0);
    wait_pulse(a, r);
    chk("mid_assign", a, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_door", door_light, 1'b0);
    chk("mid_rst_occupied", occupied, 4'b0000);
    chk("mid_rst_free", free_count, 3'd4);
    drive_events(1'b1, 1'b0, 2'd0);
    wait_pulse(a, r);
    chk("mid_rst_idle_entry", a, 1'b1);
    chk("mid_rst_reassign", occupied, 4'b0001);
    repeat (28) @(negedge clk);

    // reset while door_light is high forces it low on the next edge
    drive_events(1'b1, 1'b0, 2'd0);
    wait_pulse(a, r);
    repeat (5) @(negedge clk);
    chk("lit_door_high", door_light, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("lit_rst_door", door_light, 1'b0);
    chk("lit_rst_occupied", occupied, 4'b0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
